// File: rtl/clarvi_mem_arbiter_pkg.sv
// ============================================================================
// Module : clarvi_mem_arbiter_pkg
// Brief  : Shared types for the Clarvi memory arbiter and its ID FIFO.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package clarvi_mem_arbiter_pkg;

    typedef enum logic {
        REQ_INSTR = 1'b0,
        REQ_MAIN  = 1'b1
    } mem_requester_t;

    typedef enum logic [1:0] {
        ARB_IDLE       = 2'd0,
        ARB_HOLD_INSTR = 2'd1,
        ARB_HOLD_MAIN  = 2'd2
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/clarvi_id_fifo.sv
// ============================================================================
// Module : clarvi_id_fifo
// Brief  : DEPTH-entry FIFO of requester IDs with same-cycle push and pop.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module clarvi_id_fifo
    import clarvi_mem_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           i_push,
    input  logic           i_pop,
    input  mem_requester_t i_id,
    output mem_requester_t o_head,
    output logic           o_full,
    output logic           o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] c_DEPTH = (PTR_W + 1)'(DEPTH);

    logic [DEPTH-1:0] r_mem;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    assign o_full  = (r_count == c_DEPTH);
    assign o_empty = (r_count == '0);
    assign o_head  = mem_requester_t'(r_mem[r_rd_ptr]);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mem    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_id;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + 1'b1;
            end else if (i_pop && !i_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
        !(i_push && o_full && !i_pop));
    a_no_underflow: assert property (@(posedge clock) disable iff (!reset_n)
        !(i_pop && o_empty));

endmodule

`default_nettype wire

// File: rtl/clarvi_mem_arbiter.sv
// ============================================================================
// Module : clarvi_mem_arbiter
// Brief  : Shares one pipelined Avalon-MM master between fetch and load/store.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module clarvi_mem_arbiter
    import clarvi_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 30,
    parameter int DATA_W       = 32,
    parameter int MAX_PENDING  = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   instr_address,
    input  logic                instr_read,
    output logic                instr_waitrequest,
    output logic [DATA_W-1:0]   instr_readdata,
    output logic                instr_readdatavalid,
    input  logic [ADDR_W-1:0]   main_address,
    input  logic [DATA_W/8-1:0] main_byteenable,
    input  logic                main_read,
    input  logic                main_write,
    input  logic [DATA_W-1:0]   main_writedata,
    output logic                main_waitrequest,
    output logic [DATA_W-1:0]   main_readdata,
    output logic                main_readdatavalid,
    output logic [ADDR_W-1:0]   avm_address,
    output logic [DATA_W/8-1:0] avm_byteenable,
    output logic                avm_read,
    output logic                avm_write,
    output logic [DATA_W-1:0]   avm_writedata,
    input  logic                avm_waitrequest,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_readdatavalid,
    output logic                orphan_response
);

    localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STREAK_W-1:0] c_STREAK_MAX = STREAK_W'(STARVE_LIMIT);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic [STREAK_W-1:0] r_streak;
    logic                r_orphan;

    mem_requester_t w_winner;
    mem_requester_t w_head;
    logic           w_has_grant;
    logic           w_main_req;
    logic           w_is_read;
    logic           w_issue;
    logic           w_accept;
    logic           w_push;
    logic           w_pop;
    logic           w_full;
    logic           w_empty;

    assign w_main_req = main_read || main_write;

    // Arbitration and next state. A HOLD state pins the winner until the slave takes the command.
    always_comb begin
        w_winner    = REQ_MAIN;
        w_has_grant = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            ARB_HOLD_INSTR: begin
                w_winner    = REQ_INSTR;
                w_has_grant = instr_read;
            end
            ARB_HOLD_MAIN: begin
                w_winner    = REQ_MAIN;
                w_has_grant = w_main_req;
            end
            default: begin
                if (instr_read && (!w_main_req || r_streak == c_STREAK_MAX)) begin
                    w_winner    = REQ_INSTR;
                    w_has_grant = 1'b1;
                end else if (w_main_req) begin
                    w_winner    = REQ_MAIN;
                    w_has_grant = 1'b1;
                end
            end
        endcase

        if (r_state == ARB_IDLE) begin
            if (w_issue && avm_waitrequest) begin
                w_state_nxt = (w_winner == REQ_INSTR) ? ARB_HOLD_INSTR : ARB_HOLD_MAIN;
            end
        end else if (!w_issue || !avm_waitrequest) begin
            w_state_nxt = ARB_IDLE;
        end
    end

    // A read needs a free ID slot; a beat popping this cycle frees one.
    assign w_is_read = (w_winner == REQ_INSTR) ? instr_read : main_read;
    assign w_pop     = avm_readdatavalid && !w_empty;
    assign w_issue   = reset_n && w_has_grant && (!w_is_read || !w_full || w_pop);
    assign w_accept  = w_issue && !avm_waitrequest;
    assign w_push    = w_accept && w_is_read;

    assign avm_read       = w_issue && w_is_read;
    assign avm_write      = w_issue && (w_winner == REQ_MAIN) && main_write;
    assign avm_address    = (w_winner == REQ_INSTR) ? instr_address : main_address;
    assign avm_byteenable = (w_winner == REQ_INSTR) ? '1 : main_byteenable;
    assign avm_writedata  = main_writedata;

    assign instr_waitrequest = !(w_accept && (w_winner == REQ_INSTR));
    assign main_waitrequest  = !(w_accept && (w_winner == REQ_MAIN));

    assign instr_readdata      = avm_readdata;
    assign main_readdata       = avm_readdata;
    assign instr_readdatavalid = w_pop && (w_head == REQ_INSTR);
    assign main_readdatavalid  = w_pop && (w_head == REQ_MAIN);
    assign orphan_response     = r_orphan;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ARB_IDLE;
            r_streak <= '0;
            r_orphan <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (!instr_read || (w_accept && w_winner == REQ_INSTR)) begin
                r_streak <= '0;
            end else if (w_accept && r_streak != c_STREAK_MAX) begin
                r_streak <= r_streak + 1'b1;
            end
            if (avm_readdatavalid && w_empty) begin
                r_orphan <= 1'b1;
            end
        end
    end

    clarvi_id_fifo #(
        .DEPTH (MAX_PENDING)
    ) u_id_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_id    (w_winner),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    a_no_rw_together: assert property (@(posedge clock) disable iff (!reset_n)
        !(main_read && main_write));
    a_single_rdv: assert property (@(posedge clock) disable iff (!reset_n)
        !(instr_readdatavalid && main_readdatavalid));

endmodule

`default_nettype wire

// File: tb/tb_clarvi_mem_arbiter.sv
// ============================================================================
// Module : tb_clarvi_mem_arbiter
// Brief  : Directed scenario bench for clarvi_mem_arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_clarvi_mem_arbiter;

    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;

    logic              clock = 1'b0;
    logic              reset_n;
    logic [ADDR_W-1:0] instr_address;
    logic              instr_read;
    logic              instr_waitrequest;
    logic [DATA_W-1:0] instr_readdata;
    logic              instr_readdatavalid;
    logic [ADDR_W-1:0] main_address;
    logic [3:0]        main_byteenable;
    logic              main_read;
    logic              main_write;
    logic [DATA_W-1:0] main_writedata;
    logic              main_waitrequest;
    logic [DATA_W-1:0] main_readdata;
    logic              main_readdatavalid;
    logic [ADDR_W-1:0] avm_address;
    logic [3:0]        avm_byteenable;
    logic              avm_read;
    logic              avm_write;
    logic [DATA_W-1:0] avm_writedata;
    logic              avm_waitrequest;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_readdatavalid;
    logic              orphan_response;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    clarvi_mem_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .MAX_PENDING  (4),
        .STARVE_LIMIT (3)
    ) dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .instr_address       (instr_address),
        .instr_read          (instr_read),
        .instr_waitrequest   (instr_waitrequest),
        .instr_readdata      (instr_readdata),
        .instr_readdatavalid (instr_readdatavalid),
        .main_address        (main_address),
        .main_byteenable     (main_byteenable),
        .main_read           (main_read),
        .main_write          (main_write),
        .main_writedata      (main_writedata),
        .main_waitrequest    (main_waitrequest),
        .main_readdata       (main_readdata),
        .main_readdatavalid  (main_readdatavalid),
        .avm_address         (avm_address),
        .avm_byteenable      (avm_byteenable),
        .avm_read            (avm_read),
        .avm_write           (avm_write),
        .avm_writedata       (avm_writedata),
        .avm_waitrequest     (avm_waitrequest),
        .avm_readdata        (avm_readdata),
        .avm_readdatavalid   (avm_readdatavalid),
        .orphan_response     (orphan_response)
    );

    task automatic idle_inputs();
        instr_address     = '0;
        instr_read        = 1'b0;
        main_address      = '0;
        main_byteenable   = 4'h0;
        main_read         = 1'b0;
        main_write        = 1'b0;
        main_writedata    = '0;
        avm_waitrequest   = 1'b0;
        avm_readdata      = '0;
        avm_readdatavalid = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset_n = 1'b0;
        next_cycle();
        reset_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n    = 1'b0;
        instr_read = 1'b1;
        main_read  = 1'b1;
        #2;
        n_checks++;
        if (avm_read !== 1'b0 || avm_write !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: read=%b write=%b expected 0 0", avm_read, avm_write);
        end
        n_checks++;
        if (instr_waitrequest !== 1'b1 || main_waitrequest !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_waitreq: instr=%b main=%b expected 1 1",
                     instr_waitrequest, main_waitrequest);
        end
        n_checks++;
        if (instr_readdatavalid !== 1'b0 || main_readdatavalid !== 1'b0 || orphan_response !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rdv: instr=%b main=%b orphan=%b expected 0 0 0",
                     instr_readdatavalid, main_readdatavalid, orphan_response);
        end
        next_cycle();
        idle_inputs();
        reset_n = 1'b1;
        @(negedge clock);
        n_checks++;
        if (avm_read !== 1'b0 || avm_write !== 1'b0) begin
            n_fail++;
            $display("FAIL release_strobes: read=%b write=%b expected 0 0", avm_read, avm_write);
        end
        next_cycle();
    endtask

    task automatic test_contention();
        apply_reset();
        instr_read    = 1'b1;
        instr_address = 30'h40;
        main_read     = 1'b1;
        main_address  = 30'h50;
        @(negedge clock);
        n_checks++;
        if (main_waitrequest !== 1'b0 || instr_waitrequest !== 1'b1) begin
            n_fail++;
            $display("FAIL contention_main: main_wr=%b instr_wr=%b expected 0 1",
                     main_waitrequest, instr_waitrequest);
        end
        n_checks++;
        if (avm_address !== 30'h50 || avm_read !== 1'b1) begin
            n_fail++;
            $display("FAIL contention_bus: addr=%h read=%b expected 50 1", avm_address, avm_read);
        end
        next_cycle();
        main_read = 1'b0;
        @(negedge clock);
        n_checks++;
        if (instr_waitrequest !== 1'b0 || main_waitrequest !== 1'b1 || avm_address !== 30'h40) begin
            n_fail++;
            $display("FAIL contention_instr: instr_wr=%b main_wr=%b addr=%h expected 0 1 40",
                     instr_waitrequest, main_waitrequest, avm_address);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_starvation();
        apply_reset();
        instr_read    = 1'b1;
        instr_address = 30'h11;
        main_read     = 1'b1;
        main_address  = 30'h22;
        for (int i = 0; i < 4; i++) begin
            logic exp_main;
            exp_main = (i < 3);
            @(negedge clock);
            n_checks++;
            if (main_waitrequest !== !exp_main || instr_waitrequest !== exp_main) begin
                n_fail++;
                $display("FAIL starve_cycle%0d: main_wr=%b instr_wr=%b expected %b %b",
                         i, main_waitrequest, instr_waitrequest, !exp_main, exp_main);
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_hold();
        apply_reset();
        instr_read      = 1'b1;
        instr_address   = 30'h33;
        main_write      = 1'b1;
        main_address    = 30'h100;
        main_byteenable = 4'hF;
        main_writedata  = 32'hCAFE_F00D;
        avm_waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            n_checks++;
            if (avm_address !== 30'h100 || avm_write !== 1'b1 || avm_read !== 1'b0 ||
                main_waitrequest !== 1'b1 || instr_waitrequest !== 1'b1) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: addr=%h wr=%b rd=%b main_wr=%b instr_wr=%b expected 100 1 0 1 1",
                         i, avm_address, avm_write, avm_read, main_waitrequest, instr_waitrequest);
            end
            next_cycle();
        end
        avm_waitrequest = 1'b0;
        @(negedge clock);
        n_checks++;
        if (main_waitrequest !== 1'b0 || avm_address !== 30'h100 || avm_writedata !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL hold_accept: main_wr=%b addr=%h data=%h expected 0 100 cafef00d",
                     main_waitrequest, avm_address, avm_writedata);
        end
        next_cycle();
        main_write = 1'b0;
        @(negedge clock);
        n_checks++;
        if (instr_waitrequest !== 1'b0 || avm_read !== 1'b1 || avm_address !== 30'h33) begin
            n_fail++;
            $display("FAIL hold_then_instr: instr_wr=%b rd=%b addr=%h expected 0 1 33",
                     instr_waitrequest, avm_read, avm_address);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_routing();
        apply_reset();
        instr_read    = 1'b1;
        instr_address = 30'h10;
        @(negedge clock);
        n_checks++;
        if (instr_waitrequest !== 1'b0) begin
            n_fail++;
            $display("FAIL route_issue0: instr_wr=%b expected 0", instr_waitrequest);
        end
        next_cycle();
        instr_read   = 1'b0;
        main_read    = 1'b1;
        main_address = 30'h20;
        @(negedge clock);
        n_checks++;
        if (main_waitrequest !== 1'b0) begin
            n_fail++;
            $display("FAIL route_issue1: main_wr=%b expected 0", main_waitrequest);
        end
        next_cycle();
        main_read         = 1'b0;
        instr_read        = 1'b1;
        instr_address     = 30'h30;
        avm_readdatavalid = 1'b1;
        avm_readdata      = 32'hD0D0_0000;
        @(negedge clock);
        n_checks++;
        if (instr_waitrequest !== 1'b0 || instr_readdatavalid !== 1'b1 || main_readdatavalid !== 1'b0 ||
            instr_readdata !== 32'hD0D0_0000) begin
            n_fail++;
            $display("FAIL route_d0: instr_wr=%b irdv=%b mrdv=%b data=%h expected 0 1 0 d0d00000",
                     instr_waitrequest, instr_readdatavalid, main_readdatavalid, instr_readdata);
        end
        next_cycle();
        instr_read   = 1'b0;
        avm_readdata = 32'hD1D1_1111;
        @(negedge clock);
        n_checks++;
        if (main_readdatavalid !== 1'b1 || instr_readdatavalid !== 1'b0 || main_readdata !== 32'hD1D1_1111) begin
            n_fail++;
            $display("FAIL route_d1: mrdv=%b irdv=%b data=%h expected 1 0 d1d11111",
                     main_readdatavalid, instr_readdatavalid, main_readdata);
        end
        next_cycle();
        avm_readdata = 32'hD2D2_2222;
        @(negedge clock);
        n_checks++;
        if (instr_readdatavalid !== 1'b1 || main_readdatavalid !== 1'b0) begin
            n_fail++;
            $display("FAIL route_d2: irdv=%b mrdv=%b expected 1 0", instr_readdatavalid, main_readdatavalid);
        end
        next_cycle();
        avm_readdatavalid = 1'b0;
        main_read         = 1'b1;
        for (int i = 0; i < 4; i++) begin
            main_address = 30'h40 + 30'(i);
            @(negedge clock);
            n_checks++;
            if (main_waitrequest !== 1'b0) begin
                n_fail++;
                $display("FAIL fill_read%0d: main_wr=%b expected 0", i, main_waitrequest);
            end
            next_cycle();
        end
        main_address = 30'h50;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            n_checks++;
            if (main_waitrequest !== 1'b1 || avm_read !== 1'b0) begin
                n_fail++;
                $display("FAIL full_stall%0d: main_wr=%b rd=%b expected 1 0", i, main_waitrequest, avm_read);
            end
            next_cycle();
        end
        avm_readdatavalid = 1'b1;
        @(negedge clock);
        n_checks++;
        if (main_waitrequest !== 1'b0 || avm_read !== 1'b1 || main_readdatavalid !== 1'b1) begin
            n_fail++;
            $display("FAIL full_pop_accept: main_wr=%b rd=%b mrdv=%b expected 0 1 1",
                     main_waitrequest, avm_read, main_readdatavalid);
        end
        next_cycle();
        main_read = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            n_checks++;
            if (main_readdatavalid !== 1'b1 || instr_readdatavalid !== 1'b0) begin
                n_fail++;
                $display("FAIL drain%0d: mrdv=%b irdv=%b expected 1 0", i, main_readdatavalid, instr_readdatavalid);
            end
            next_cycle();
        end
        avm_readdatavalid = 1'b0;
        @(negedge clock);
        n_checks++;
        if (orphan_response !== 1'b0) begin
            n_fail++;
            $display("FAIL route_no_orphan: orphan=%b expected 0", orphan_response);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_orphan();
        apply_reset();
        instr_read    = 1'b1;
        instr_address = 30'h44;
        @(negedge clock);
        n_checks++;
        if (instr_waitrequest !== 1'b0) begin
            n_fail++;
            $display("FAIL orphan_issue: instr_wr=%b expected 0", instr_waitrequest);
        end
        next_cycle();
        instr_read = 1'b0;
        reset_n    = 1'b0;
        #2;
        n_checks++;
        if (instr_waitrequest !== 1'b1 || main_waitrequest !== 1'b1) begin
            n_fail++;
            $display("FAIL orphan_in_reset: instr_wr=%b main_wr=%b expected 1 1",
                     instr_waitrequest, main_waitrequest);
        end
        next_cycle();
        reset_n           = 1'b1;
        avm_readdatavalid = 1'b1;
        avm_readdata      = 32'hBAD0_BEEF;
        @(negedge clock);
        n_checks++;
        if (instr_readdatavalid !== 1'b0 || main_readdatavalid !== 1'b0) begin
            n_fail++;
            $display("FAIL orphan_dropped: irdv=%b mrdv=%b expected 0 0",
                     instr_readdatavalid, main_readdatavalid);
        end
        next_cycle();
        avm_readdatavalid = 1'b0;
        @(negedge clock);
        n_checks++;
        if (orphan_response !== 1'b1) begin
            n_fail++;
            $display("FAIL orphan_flag: orphan=%b expected 1", orphan_response);
        end
        next_cycle();
        idle_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        #1;
        test_reset();
        test_contention();
        test_starvation();
        test_hold();
        test_routing();
        test_orphan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
